// File: rtl/e_mdu_pkg.sv
// -----------------------------------------------------------------------------
// mdu_pkg : shared definitions for the E-stage multiply/divide unit.
//   - 4-bit MDU operation codes driven on E_MDUOp
//   - default MULT/DIV busy latencies
//   - pending-result mode used between start and completion
//   - is_mdu_start(): true for ops that launch a multi-cycle operation
// Optional feature macro: MDU_MADD_EN (MADD/MADDU/MSUB/MSUBU become start ops).
// -----------------------------------------------------------------------------
package mdu_pkg;

  localparam logic [3:0] NONE  = 4'd0;
  localparam logic [3:0] MULT  = 4'd1;
  localparam logic [3:0] MULTU = 4'd2;
  localparam logic [3:0] DIV   = 4'd3;
  localparam logic [3:0] DIVU  = 4'd4;
  localparam logic [3:0] MTHI  = 4'd5;
  localparam logic [3:0] MTLO  = 4'd6;
  localparam logic [3:0] MFHI  = 4'd7;
  localparam logic [3:0] MFLO  = 4'd8;
  localparam logic [3:0] MADD  = 4'd9;
  localparam logic [3:0] MADDU = 4'd10;
  localparam logic [3:0] MSUB  = 4'd11;
  localparam logic [3:0] MSUBU = 4'd12;

  localparam int MULT_LAT_DEF = 5;
  localparam int DIV_LAT_DEF  = 10;

  // What happens to HI/LO when the in-flight operation completes.
  typedef enum logic [1:0] {
    PEND_NONE = 2'd0,  // nothing (divide by zero)
    PEND_LOAD = 2'd1,  // {HI,LO} = pending
    PEND_ADD  = 2'd2,  // {HI,LO} += pending
    PEND_SUB  = 2'd3   // {HI,LO} -= pending
  } pend_mode_e;

  function automatic logic is_mdu_start(input logic [3:0] op);
    logic r;
    case (op)
      MULT, MULTU, DIV, DIVU: r = 1'b1;
`ifdef MDU_MADD_EN
      MADD, MADDU, MSUB, MSUBU: r = 1'b1;
`endif
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic is_div_op(input logic [3:0] op);
    return (op == DIV) || (op == DIVU);
  endfunction

endpackage

// File: rtl/e_mdu_if.sv
// -----------------------------------------------------------------------------
// e_mdu_if : E-stage operand/result bundle of the MDU.
//   E_MDUA/E_MDUB/E_MDUOp : operands and op code from the E-stage muxes
//   E_MDURe               : MFHI/MFLO read data
//   E_MDUBusy             : operation in flight (to hazard unit)
//   E_HI/E_LO             : current HI/LO registers (trace)
// master = pipeline side, slave = MDU.
// -----------------------------------------------------------------------------
interface e_mdu_if;
  logic [31:0] E_MDUA;
  logic [31:0] E_MDUB;
  logic [3:0]  E_MDUOp;
  logic [31:0] E_MDURe;
  logic        E_MDUBusy;
  logic [31:0] E_HI;
  logic [31:0] E_LO;

  modport master (
    output E_MDUA, E_MDUB, E_MDUOp,
    input  E_MDURe, E_MDUBusy, E_HI, E_LO
  );

  modport slave (
    input  E_MDUA, E_MDUB, E_MDUOp,
    output E_MDURe, E_MDUBusy, E_HI, E_LO
  );
endinterface

// File: rtl/e_mdu_calc.sv
// -----------------------------------------------------------------------------
// e_mdu_calc : purely combinational 64-bit result of a mult/div op.
//   a, b   in  32  operands
//   op     in  4   MDU op code
//   res    out 64  {hi,lo}: product, or {remainder,quotient} for DIV/DIVU
//   valid  out 1   result should be written (0 for divide by zero / non-start ops)
// MADD-family ops reuse the plain product; accumulation happens in e_mdu.
// -----------------------------------------------------------------------------
module e_mdu_calc
  import mdu_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [3:0]  op,
  output logic [63:0] res,
  output logic        valid
);

  logic [63:0] sa_s, sb_s, prod_s_s, prod_u_s;
  logic [31:0] abs_a_s, abs_b_s, b_safe_s, abs_b_safe_s;
  logic [31:0] mq_s, mr_s, sq_s, sr_s, uq_s, ur_s;
  logic        b_zero_s;

  // Products, and divides done on magnitudes so INT_MIN / -1 wraps cleanly.
  always_comb begin
    sa_s     = {{32{a[31]}}, a};
    sb_s     = {{32{b[31]}}, b};
    prod_s_s = sa_s * sb_s;
    prod_u_s = {32'd0, a} * {32'd0, b};

    b_zero_s     = (b == 32'd0);
    // Divisor forced to 1 when zero: result is discarded, this only avoids X.
    b_safe_s     = b_zero_s ? 32'd1 : b;
    abs_a_s      = a[31] ? (32'd0 - a) : a;
    abs_b_s      = b[31] ? (32'd0 - b) : b;
    abs_b_safe_s = b_zero_s ? 32'd1 : abs_b_s;

    mq_s = abs_a_s / abs_b_safe_s;
    mr_s = abs_a_s % abs_b_safe_s;
    // Truncating division: quotient negative on sign mismatch, remainder follows A.
    sq_s = (a[31] ^ b[31]) ? (32'd0 - mq_s) : mq_s;
    sr_s = a[31] ? (32'd0 - mr_s) : mr_s;

    uq_s = a / b_safe_s;
    ur_s = a % b_safe_s;
  end

  // Result select.
  always_comb begin
    res   = 64'd0;
    valid = 1'b0;
    case (op)
      MULT, MADD, MSUB: begin
        res   = prod_s_s;
        valid = 1'b1;
      end
      MULTU, MADDU, MSUBU: begin
        res   = prod_u_s;
        valid = 1'b1;
      end
      DIV: begin
        res   = {sr_s, sq_s};
        valid = !b_zero_s;
      end
      DIVU: begin
        res   = {ur_s, uq_s};
        valid = !b_zero_s;
      end
      default: begin
        res   = 64'd0;
        valid = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/e_mdu.sv
// -----------------------------------------------------------------------------
// e_mdu : E-stage multi-cycle multiply/divide unit owning HI/LO.
// Ports:
//   clk      in  1   pipeline clock (rising edge)
//   reset_n  in  1   asynchronous active-low reset
//   bus      slave modport of e_mdu_if (operands, op, read data, busy, HI/LO)
// Parameters:
//   MULT_LAT  busy cycles after a MULT/MULTU(/MADD*) start (>=1)
//   DIV_LAT   busy cycles after a DIV/DIVU start (>=1)
// The result is computed at start and held in a pending register; HI/LO take
// it on the edge the counter goes 1->0. MT*/start ops are ignored while busy.
// Optional macro MDU_MADD_EN: MADD/MADDU/MSUB/MSUBU accumulate the product
// into the HI/LO value present at completion. Undefined: they act as NONE.
// -----------------------------------------------------------------------------
module e_mdu
  import mdu_pkg::*;
#(
  parameter int MULT_LAT = MULT_LAT_DEF,
  parameter int DIV_LAT  = DIV_LAT_DEF
)(
  input  logic    clk,
  input  logic    reset_n,
  e_mdu_if.slave  bus
);

  localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);

  logic [31:0]      hi_q, hi_d, lo_q, lo_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [63:0]      pend_q, pend_d;
  pend_mode_e       pmode_q, pmode_d;
  logic             busy_q, busy_d;

  logic [63:0]      calc_res_s;
  logic             calc_valid_s;
  logic [63:0]      acc_s;
  pend_mode_e       start_mode_s;
  logic [31:0]      re_s;

  e_mdu_calc u_calc (
    .a     (bus.E_MDUA),
    .b     (bus.E_MDUB),
    .op    (bus.E_MDUOp),
    .res   (calc_res_s),
    .valid (calc_valid_s)
  );

  // Completion action chosen at start time.
  always_comb begin
    start_mode_s = PEND_NONE;
    case (bus.E_MDUOp)
`ifdef MDU_MADD_EN
      MADD, MADDU: start_mode_s = PEND_ADD;
      MSUB, MSUBU: start_mode_s = PEND_SUB;
`endif
      default:     start_mode_s = calc_valid_s ? PEND_LOAD : PEND_NONE;
    endcase
  end

  // Next-state: countdown/completion while busy, else start or MT write.
  always_comb begin
    hi_d    = hi_q;
    lo_d    = lo_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    pmode_d = pmode_q;
    acc_s   = {hi_q, lo_q};
    if (busy_q) begin
      cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
      if (cnt_q == {{(CNT_W-1){1'b0}}, 1'b1}) begin
        case (pmode_q)
          PEND_LOAD: acc_s = pend_q;
`ifdef MDU_MADD_EN
          PEND_ADD:  acc_s = {hi_q, lo_q} + pend_q;
          PEND_SUB:  acc_s = {hi_q, lo_q} - pend_q;
`endif
          default:   acc_s = {hi_q, lo_q};
        endcase
        hi_d    = acc_s[63:32];
        lo_d    = acc_s[31:0];
        pend_d  = 64'd0;
        pmode_d = PEND_NONE;
      end else begin
        pend_d  = pend_q;
      end
    end else if (is_mdu_start(bus.E_MDUOp)) begin
      cnt_d   = is_div_op(bus.E_MDUOp) ? CNT_W'(DIV_LAT) : CNT_W'(MULT_LAT);
      pend_d  = calc_res_s;
      pmode_d = start_mode_s;
    end else begin
      case (bus.E_MDUOp)
        MTHI:    hi_d = bus.E_MDUA;
        MTLO:    lo_d = bus.E_MDUA;
        default: begin
          hi_d = hi_q;
          lo_d = lo_q;
        end
      endcase
    end
    busy_d = (cnt_d != {CNT_W{1'b0}});
  end

  // State registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      cnt_q   <= {CNT_W{1'b0}};
      pend_q  <= 64'd0;
      pmode_q <= PEND_NONE;
      busy_q  <= 1'b0;
    end else begin
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      pmode_q <= pmode_d;
      busy_q  <= busy_d;
    end
  end

  // MF read port: combinational from the current (pre-edge) HI/LO.
  always_comb begin
    case (bus.E_MDUOp)
      MFHI:    re_s = hi_q;
      MFLO:    re_s = lo_q;
      default: re_s = 32'd0;
    endcase
  end

  assign bus.E_MDURe   = re_s;
  assign bus.E_MDUBusy = busy_q;
  assign bus.E_HI      = hi_q;
  assign bus.E_LO      = lo_q;

endmodule
